// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the pcihellocore PIO: register word addresses and
// the edge-selection encodings used by the EDGE_TYPE parameter.
package pcihellocore_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pcihellocore_sync_bus.sv
// WIDTH-bit multi-stage synchroniser for asynchronous pad inputs.
// Every stage resets to 0; d_out is the last stage.
module pcihellocore_sync_bus #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcihellocore_pio_irq.sv
// Avalon-MM PIO with set/clear output access, direction register, per-bit
// edge capture on synchronised inputs and a registered level interrupt.
module pcihellocore_pio_irq
    import pcihellocore_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] in_prev_q, in_prev_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_word;
    logic             wr_en;

    pcihellocore_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (in_port),
        .d_out   (in_sync)
    );

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~in_sync & in_prev_q;
            EDGE_ANY:  edge_det = in_sync ^ in_prev_q;
            default:   edge_det = in_sync & ~in_prev_q;
        endcase
    end

    always_comb begin
        wr_en      = chipselect & ~write_n;
        wd         = writedata[WIDTH-1:0];
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        cap_clr    = '0;
        in_prev_d  = in_sync;

        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_out_d = wd;
                ADDR_DIR:      dir_d      = wd;
                ADDR_IRQ_MASK: irq_mask_d = wd;
                ADDR_EDGE_CAP: cap_clr    = wd;
                ADDR_OUTSET:   data_out_d = data_out_q | wd;
                ADDR_OUTCLR:   data_out_d = data_out_q & ~wd;
                default:       ;
            endcase
        end

        // A fresh edge wins over a simultaneous write-1-to-clear.
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            in_prev_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            in_prev_q  <= in_prev_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        case (address)
            ADDR_DATA:     rd_word = in_sync;
            ADDR_DIR:      rd_word = dir_q;
            ADDR_IRQ_MASK: rd_word = irq_mask_q;
            ADDR_EDGE_CAP: rd_word = edge_cap_q;
            ADDR_OUTSET:   rd_word = data_out_q;
            ADDR_OUTCLR:   rd_word = data_out_q;
            default:       rd_word = '0;
        endcase
        readdata              = '0;
        readdata[WIDTH-1:0]   = rd_word;
    end

    assign out_port = data_out_q;
    assign out_oe   = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pcihellocore_pio_irq.sv
// Directed bench: instance A is 32-bit rising-edge, instance B is 8-bit
// any-edge with three synchroniser stages; both share clock, reset and bus.
module tb_pcihellocore_pio_irq;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic [31:0] in_port_a, out_port_a, out_oe_a;
    logic [7:0]  in_port_b, out_port_b, out_oe_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_errors = 0;

    pcihellocore_pio_irq #(
        .WIDTH(32), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port_a), .out_port(out_port_a), .out_oe(out_oe_a), .irq(irq_a)
    );

    pcihellocore_pio_irq #(
        .WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_TYPE(2), .SYNC_STAGES(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_port_b), .out_port(out_port_b), .out_oe(out_oe_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one write cycle starting at a negedge; returns at the next negedge.
    task automatic bus_write(input bit sel_b, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_a      = !sel_b;
        cs_b      = sel_b;
        @(negedge clk);
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
    endtask

    task automatic check_rd(input bit sel_b, input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, sel_b ? rd_b : rd_a, exp);
    endtask

    initial begin
        logic [31:0] rst_rd [8];
        rst_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5, 32'hA5, 32'h0, 32'h0};

        reset_n   = 1'b0;
        address   = 3'd0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = 32'h0;
        in_port_a = 32'h0;
        in_port_b = 8'h0;
        tick(3);
        reset_n = 1'b1;
        #1;

        // Reset state
        check("rst_out_port", out_port_a, 32'hA5);
        check("rst_out_oe", out_oe_a, 32'h0);
        check("rst_irq", {31'h0, irq_a}, 32'h0);
        check("rst_out_port_b", {24'h0, out_port_b}, 32'h3C);
        for (int i = 0; i < 8; i++)
            check_rd(0, 3'(i), rst_rd[i], $sformatf("rst_read_addr%0d", i));

        // Output register: direct write, set, clear, ignored addresses
        tick(1);
        bus_write(0, 3'd0, 32'hF0);
        check("data_write", out_port_a, 32'hF0);
        bus_write(0, 3'd4, 32'h0F);
        check("outset", out_port_a, 32'hFF);
        bus_write(0, 3'd5, 32'h81);
        check("outclr", out_port_a, 32'h7E);
        check_rd(0, 3'd5, 32'h7E, "outclr_read");
        bus_write(0, 3'd6, 32'hFFFF_FFFF);
        bus_write(0, 3'd7, 32'hFFFF_FFFF);
        check("addr67_ignored", out_port_a, 32'h7E);
        check_rd(0, 3'd6, 32'h0, "addr6_read");
        bus_write(0, 3'd1, 32'h3C);
        check("dir_out_oe", out_oe_a, 32'h3C);
        check_rd(0, 3'd1, 32'h3C, "dir_read");

        // Rising edge on bit 0 with mask bit 0 set
        bus_write(0, 3'd2, 32'h1);
        in_port_a[0] = 1'b1;
        tick(2);
        check_rd(0, 3'd3, 32'h0, "cap_before_latency");
        check_rd(0, 3'd0, 32'h1, "data_in_sync");
        tick(1);
        check_rd(0, 3'd3, 32'h1, "cap_bit0");
        check("irq_not_yet", {31'h0, irq_a}, 32'h0);
        tick(1);
        check("irq_assert", {31'h0, irq_a}, 32'h1);
        bus_write(0, 3'd3, 32'h1);
        check_rd(0, 3'd3, 32'h0, "w1c_bit0");
        tick(1);
        check("irq_deassert", {31'h0, irq_a}, 32'h0);

        // W1C on bit 3 in the same cycle the edge lands: set wins
        in_port_a[3] = 1'b1;
        tick(2);
        bus_write(0, 3'd3, 32'h8);
        check_rd(0, 3'd3, 32'h8, "set_wins_w1c");
        bus_write(0, 3'd3, 32'h8);
        check_rd(0, 3'd3, 32'h0, "w1c_bit3");
        check("irq_bit3_masked", {31'h0, irq_a}, 32'h0);

        // Masked capture on bit 5, then unmask
        bus_write(0, 3'd2, 32'h0);
        in_port_a[5] = 1'b1;
        tick(3);
        check_rd(0, 3'd3, 32'h20, "cap_bit5_masked");
        tick(1);
        check("irq_masked", {31'h0, irq_a}, 32'h0);
        bus_write(0, 3'd2, 32'h20);
        tick(1);
        check("irq_unmask", {31'h0, irq_a}, 32'h1);
        in_port_a[0] = 1'b0;
        tick(4);
        check_rd(0, 3'd3, 32'h20, "falling_ignored");

        // 8-bit any-edge instance
        in_port_b[7] = 1'b1;
        tick(3);
        check_rd(1, 3'd3, 32'h0, "b_cap_before_latency");
        tick(1);
        check_rd(1, 3'd3, 32'h80, "b_cap_rise");
        bus_write(1, 3'd3, 32'h80);
        check_rd(1, 3'd3, 32'h0, "b_w1c");
        in_port_b[7] = 1'b0;
        tick(4);
        check_rd(1, 3'd3, 32'h80, "b_cap_fall");
        bus_write(1, 3'd0, 32'hFFFF_FFFF);
        check("b_out_port_trunc", {24'h0, out_port_b}, 32'hFF);
        check_rd(1, 3'd4, 32'h0000_00FF, "b_read_upper_zero");
        bus_write(1, 3'd1, 32'hFFFF_FFFF);
        check("b_out_oe", {24'h0, out_oe_b}, 32'hFF);
        bus_write(1, 3'd2, 32'h80);
        tick(1);
        check("b_irq", {31'h0, irq_b}, 32'h1);

        // Async reset with an edge in flight, inputs held high through reset
        in_port_b[7] = 1'b1;
        tick(2);
        reset_n = 1'b0;
        #1;
        check("arst_b_out_port", {24'h0, out_port_b}, 32'h3C);
        check("arst_b_out_oe", {24'h0, out_oe_b}, 32'h0);
        check("arst_b_irq", {31'h0, irq_b}, 32'h0);
        check("arst_a_out_port", out_port_a, 32'hA5);
        check("arst_a_irq", {31'h0, irq_a}, 32'h0);
        check_rd(1, 3'd3, 32'h0, "arst_b_cap");
        tick(2);
        reset_n = 1'b1;
        #1;
        check_rd(1, 3'd2, 32'h0, "post_rst_b_mask");
        check_rd(1, 3'd3, 32'h0, "post_rst_b_cap");
        tick(3);
        check_rd(0, 3'd3, 32'h28, "post_rst_a_high_edge");
        tick(1);
        check_rd(1, 3'd3, 32'h80, "post_rst_b_high_edge");
        check("post_rst_b_irq", {31'h0, irq_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
